aes_spi_frame_slave: RTL and testbench
======================================

# aes_spi_frame_slave

SPI slave framing front-end for the AES encryption core. It deserialises one request frame from the SPI master: 16 plaintext bytes, 1 key-size byte and 32 key bytes, MSB first. It then launches the core, waits for the result, and serialises the 16 ciphertext bytes back to the master. It sits between the SPI pins (`cs`, `sclk`, `mosi`, `miso`) and the AES datapath, and exposes the same `enc_sending`/`done` handshake the master-side controller already polls.

## Interface
- `SYNC_STAGES`, default 2: synchroniser depth for `cs`, `sclk`, `mosi` into `clk`.
- `clk` input 1: system clock; all logic is on the rising edge.
- `reset` input 1: asynchronous, active-low reset (asserts immediately, release is synchronised internally).
- `cs` input 1: chip select, active-low; one byte transfer per assertion.
- `sclk` input 1: SPI clock, idle-low (mode 0). Must be at most clk/8.
- `mosi` input 1: serial data from the master; sampled on the rising edge of `sclk`.
- `miso` output 1: serial data to the master; changes on the falling edge of `sclk`; reset value 0.
- `done` output 1: byte-complete level; reset value 0.
- `enc_sending` output 1: high while ciphertext bytes are being transmitted; reset value 0.
- `key_err` output 1: sticky flag for an invalid key-size byte; reset value 0.
- `core_start` output 1: one-clk launch pulse to the core; reset value 0.
- `core_plain` output 128: assembled plaintext; reset value 0.
- `core_key` output 256: assembled key, left-justified; reset value 0.
- `core_key_size` output 8: key length in bytes (16, 24 or 32); reset value 0.
- `core_done` input 1: core result valid, one-clk pulse.
- `core_cipher` input 128: ciphertext; captured when `core_done` is high.

## Operation
- Edges are detected on the synchronised `sclk`: rise means sample `mosi` into the RX shift register; fall means shift the TX register and drive `miso` from its MSB.
- A 3-bit bit counter completes a byte on the 8th rising edge, which raises `done`. `done` stays high until the next falling edge of `cs` and then clears.
- `cs` rising (deassertion) mid-byte: discard the partial byte, clear the bit counter, and hold the byte counter and state unchanged.
- States:
  - RX_PLAIN: bytes 0..15 go into `core_plain[127-8k -: 8]`. After byte 15, go to RX_KSIZE.
  - RX_KSIZE: the byte goes to `core_key_size`. If it is not 16, 24 or 32, set `key_err` and mark the frame bad. Go to RX_KEY.
  - RX_KEY: always exactly 32 bytes, into `core_key[255-8k -: 8]`. After byte 31: a good frame pulses `core_start` and goes to WAIT_CORE; a bad frame returns to RX_PLAIN.
  - WAIT_CORE: on `core_done`, capture `core_cipher` into the TX buffer, preload the TX shift register with `cipher[127:120]`, raise `enc_sending`, and go to TX_CIPHER. `done` is forced low in this state. Bytes clocked by the master here are ignored and `miso` is 0.
  - TX_CIPHER: each completed byte (8 `sclk` rises) loads the next ciphertext byte. After byte 15 completes, `enc_sending` falls and the state goes to RX_PLAIN.
- The first bit of each TX byte is on `miso` before the first rising edge of `sclk`. It is loaded when `cs` falls.
- `key_err` clears only on reset.
- A byte counter (0..31) is reused by every state and cleared on each state change.
- Reset mid-operation: every register returns to its reset value immediately and the state goes to RX_PLAIN.

## Timing
- Input sync latency is `SYNC_STAGES` clk cycles. The `sclk` edge is detected one clk after that.
- `done` rises 1 clk after the detected 8th `sclk` rise.
- `core_start` is high for exactly 1 clk, asserted 1 clk after the last key byte completes.
- `enc_sending` rises 1 clk after `core_done`.
- `miso` update: 1 clk after the detected `sclk` fall.
- A `core_done` arriving in any state other than WAIT_CORE is ignored.

## Configuration
- `SPI_RX_ECHO_EN` defined: during the RX states, `miso` echoes the previously received byte, MSB first, for link checking. The first byte of a frame echoes 0x00.
- `SPI_RX_ECHO_EN` undefined: `miso` is held 0 in every state except TX_CIPHER.

## Test plan
- AES-128: plaintext 00112233445566778899aabbccddeeff, key size 0x10, key 000102…0f followed by 16 zero bytes, core model returns 69c4e0d86a7b0430d8cdb78070b4c55a. Required: one `core_start`, `core_key_size`=0x10, and the 16 `miso` bytes equal the cipher.
- AES-256: key 000102…1f, key size 0x20. Required: `core_key` equals the full key and the echoed result is 8ea2b7ca516745bfeafc49904b496089.
- Invalid key size 0x11. Required: `key_err`=1, no `core_start`, and the state returns to RX_PLAIN after 32 key bytes; the next valid frame still succeeds.
- `cs` deasserted after 3 bits of byte 5. Required: the partial byte is dropped, and resending byte 5 yields the correct `core_plain`.
- Drive `reset`=0 during TX_CIPHER byte 7. Required: `enc_sending`, `done`, `miso` and `core_start` all go to 0 at once; after release, a full frame completes normally.
- With `SPI_RX_ECHO_EN`: byte 2 returns byte 1 on `miso`. Without it: `miso`=0 throughout RX.

Source files
------------

// File: rtl/aes_spi_frame_slave.sv
//==============================================================================
// Module  : aes_spi_frame_slave
// Purpose : SPI mode-0 slave framing front-end for the AES core. Receives a
//           49-byte request frame (16 plaintext, 1 key-size, 32 key bytes,
//           MSB first), launches the core, then returns the 16 ciphertext
//           bytes on miso.
// Ports   : clk, reset (async active-low)     - system clock / reset
//           cs, sclk, mosi / miso             - SPI pins (cs active-low)
//           done, enc_sending, key_err        - status to the master side
//           core_start, core_plain, core_key,
//           core_key_size / core_done,
//           core_cipher                       - AES core handshake
// Config  : define SPI_RX_ECHO_EN to echo the previous received byte on
//           miso during the receive states.
// Revision: 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module aes_spi_frame_slave #(
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cs,
    input  logic         sclk,
    input  logic         mosi,
    output logic         miso,
    output logic         done,
    output logic         enc_sending,
    output logic         key_err,
    output logic         core_start,
    output logic [127:0] core_plain,
    output logic [255:0] core_key,
    output logic [7:0]   core_key_size,
    input  logic         core_done,
    input  logic [127:0] core_cipher
);

    typedef enum logic [2:0] {
        RX_PLAIN  = 3'd0,
        RX_KSIZE  = 3'd1,
        RX_KEY    = 3'd2,
        WAIT_CORE = 3'd3,
        TX_CIPHER = 3'd4
    } state_t;

    // Reset asserts asynchronously, releases after two clk edges.
    logic [1:0] rst_sync_q;
    logic       rst_n_int;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rst_sync_q <= 2'b00;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n_int = rst_sync_q[1];

    logic [SYNC_STAGES-1:0] cs_sync_q, sclk_sync_q, mosi_sync_q;
    logic                   cs_prev_q, sclk_prev_q;

    state_t         state_q, state_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic [4:0]     byte_cnt_q, byte_cnt_d;
    logic [7:0]     rx_sr_q, rx_sr_d;
    logic [7:0]     tx_sr_q, tx_sr_d;
    logic [7:0]     tx_byte_q, tx_byte_d;   // byte to present at next cs fall
    logic [127:0]   tx_buf_q, tx_buf_d;
    logic           frame_bad_q, frame_bad_d;
    logic           miso_q, miso_d;
    logic           done_q, done_d;
    logic           enc_q, enc_d;
    logic           key_err_q, key_err_d;
    logic           start_q, start_d;
    logic [127:0]   plain_q, plain_d;
    logic [255:0]   key_q, key_d;
    logic [7:0]     ksize_q, ksize_d;

    logic w_cs_s, w_sclk_s, w_mosi_s;
    logic w_cs_fall, w_cs_rise, w_sclk_rise, w_sclk_fall, w_byte_done;
    logic [7:0] w_rx_byte;
    logic [6:0] w_plain_hi;
    logic [7:0] w_key_hi;

    assign w_cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign w_sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign w_mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign w_cs_fall   = ~w_cs_s & cs_prev_q;
    assign w_cs_rise   = w_cs_s & ~cs_prev_q;
    // sclk activity only counts while the slave is selected
    assign w_sclk_rise = w_sclk_s & ~sclk_prev_q & ~w_cs_s;
    assign w_sclk_fall = ~w_sclk_s & sclk_prev_q & ~w_cs_s;
    assign w_rx_byte   = {rx_sr_q[6:0], w_mosi_s};
    assign w_byte_done = w_sclk_rise && (bit_cnt_q == 3'd7);
    assign w_plain_hi  = 7'd127 - {byte_cnt_q[3:0], 3'b000};
    assign w_key_hi    = 8'd255 - {byte_cnt_q, 3'b000};

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        rx_sr_d     = rx_sr_q;
        tx_sr_d     = tx_sr_q;
        tx_byte_d   = tx_byte_q;
        tx_buf_d    = tx_buf_q;
        frame_bad_d = frame_bad_q;
        miso_d      = miso_q;
        done_d      = done_q;
        enc_d       = enc_q;
        key_err_d   = key_err_q;
        start_d     = 1'b0;
        plain_d     = plain_q;
        key_d       = key_q;
        ksize_d     = ksize_q;

        // First bit of the byte must be on miso before the first sclk rise.
        if (w_cs_fall) begin
            done_d  = 1'b0;
            tx_sr_d = tx_byte_q;
            miso_d  = tx_byte_q[7];
        end
        // Abandoned partial byte: drop it, keep byte counter and state.
        if (w_cs_rise) begin
            bit_cnt_d = 3'd0;
            rx_sr_d   = 8'h00;
        end
        // bit_cnt==0 means the byte just completed (or not started); the
        // trailing fall must not shift the freshly reloaded byte.
        if (w_sclk_fall && (bit_cnt_q != 3'd0)) begin
            tx_sr_d = {tx_sr_q[6:0], 1'b0};
            miso_d  = tx_sr_q[6];
        end
        if (w_sclk_rise) begin
            rx_sr_d   = w_rx_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
        end

        case (state_q)
            RX_PLAIN: if (w_byte_done) begin
                done_d                  = 1'b1;
                plain_d[w_plain_hi -: 8] = w_rx_byte;
                tx_byte_d               = w_rx_byte;
                if (byte_cnt_q == 5'd15) begin
                    state_d    = RX_KSIZE;
                    byte_cnt_d = 5'd0;
                end else begin
                    byte_cnt_d = byte_cnt_q + 5'd1;
                end
            end
            RX_KSIZE: if (w_byte_done) begin
                done_d     = 1'b1;
                ksize_d    = w_rx_byte;
                tx_byte_d  = w_rx_byte;
                state_d    = RX_KEY;
                byte_cnt_d = 5'd0;
                if (!(w_rx_byte == 8'd16 || w_rx_byte == 8'd24 || w_rx_byte == 8'd32)) begin
                    key_err_d   = 1'b1;
                    frame_bad_d = 1'b1;
                end
            end
            RX_KEY: if (w_byte_done) begin
                done_d               = 1'b1;
                key_d[w_key_hi -: 8] = w_rx_byte;
                tx_byte_d            = w_rx_byte;
                if (byte_cnt_q == 5'd31) begin
                    byte_cnt_d  = 5'd0;
                    frame_bad_d = 1'b0;
                    tx_byte_d   = 8'h00;   // a new frame echoes 0x00 first
                    if (frame_bad_q) begin
                        state_d = RX_PLAIN;
                    end else begin
                        state_d = WAIT_CORE;
                        start_d = 1'b1;
                    end
                end else begin
                    byte_cnt_d = byte_cnt_q + 5'd1;
                end
            end
            WAIT_CORE: if (core_done) begin
                tx_buf_d   = core_cipher;
                tx_sr_d    = core_cipher[127:120];
                tx_byte_d  = core_cipher[127:120];
                enc_d      = 1'b1;
                state_d    = TX_CIPHER;
                byte_cnt_d = 5'd0;
            end
            TX_CIPHER: if (w_byte_done) begin
                done_d = 1'b1;
                if (byte_cnt_q == 5'd15) begin
                    enc_d      = 1'b0;
                    state_d    = RX_PLAIN;
                    byte_cnt_d = 5'd0;
                    tx_byte_d  = 8'h00;
                end else begin
                    byte_cnt_d = byte_cnt_q + 5'd1;
                    tx_buf_d   = {tx_buf_q[119:0], 8'h00};
                    tx_byte_d  = tx_buf_q[119:112];
                end
            end
            default: begin
                state_d    = RX_PLAIN;
                byte_cnt_d = 5'd0;
            end
        endcase

        if (state_d == WAIT_CORE) done_d = 1'b0;
`ifdef SPI_RX_ECHO_EN
        if (state_d == WAIT_CORE) miso_d = 1'b0;
`else
        if (state_d != TX_CIPHER) miso_d = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            cs_sync_q   <= '1;
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            cs_prev_q   <= 1'b1;
            sclk_prev_q <= 1'b0;
            state_q     <= RX_PLAIN;
            bit_cnt_q   <= 3'd0;
            byte_cnt_q  <= 5'd0;
            rx_sr_q     <= 8'h00;
            tx_sr_q     <= 8'h00;
            tx_byte_q   <= 8'h00;
            tx_buf_q    <= '0;
            frame_bad_q <= 1'b0;
            miso_q      <= 1'b0;
            done_q      <= 1'b0;
            enc_q       <= 1'b0;
            key_err_q   <= 1'b0;
            start_q     <= 1'b0;
            plain_q     <= '0;
            key_q       <= '0;
            ksize_q     <= 8'h00;
        end else begin
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs};
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            cs_prev_q   <= w_cs_s;
            sclk_prev_q <= w_sclk_s;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            rx_sr_q     <= rx_sr_d;
            tx_sr_q     <= tx_sr_d;
            tx_byte_q   <= tx_byte_d;
            tx_buf_q    <= tx_buf_d;
            frame_bad_q <= frame_bad_d;
            miso_q      <= miso_d;
            done_q      <= done_d;
            enc_q       <= enc_d;
            key_err_q   <= key_err_d;
            start_q     <= start_d;
            plain_q     <= plain_d;
            key_q       <= key_d;
            ksize_q     <= ksize_d;
        end
    end

    assign miso          = miso_q;
    assign done          = done_q;
    assign enc_sending   = enc_q;
    assign key_err       = key_err_q;
    assign core_start    = start_q;
    assign core_plain    = plain_q;
    assign core_key      = key_q;
    assign core_key_size = ksize_q;

endmodule

`default_nettype wire

// File: tb/tb_aes_spi_frame_slave.sv
//==============================================================================
// Module  : tb_aes_spi_frame_slave
// Purpose : Directed self-checking bench for aes_spi_frame_slave with an SPI
//           master model and a fixed-latency AES core model.
// Revision: 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_aes_spi_frame_slave;

    localparam logic [127:0] C_PLAIN  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C_PLAIN2 = 128'hdeadbeef0123456789abcdeffedcba98;
    localparam logic [255:0] C_KEY128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] C_KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] C_CIPH128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C_CIPH256 = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         cs = 1'b1;
    logic         sclk = 1'b0;
    logic         mosi = 1'b0;
    logic         core_done = 1'b0;
    logic [127:0] core_cipher = '0;
    logic         miso, done, enc_sending, key_err, core_start;
    logic [127:0] core_plain;
    logic [255:0] core_key;
    logic [7:0]   core_key_size;

    int checks = 0;
    int failures = 0;
    int start_cnt = 0;
    logic [7:0] rx_log [0:48];
    logic [7:0] rx_or;

    aes_spi_frame_slave #(.SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .cs(cs), .sclk(sclk), .mosi(mosi),
        .miso(miso), .done(done), .enc_sending(enc_sending), .key_err(key_err),
        .core_start(core_start), .core_plain(core_plain), .core_key(core_key),
        .core_key_size(core_key_size), .core_done(core_done), .core_cipher(core_cipher)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // AES core model: fixed latency, result chosen by the requested key size.
    initial begin
        logic [7:0] ks;
        forever begin
            @(posedge clk);
            if (core_start) begin
                start_cnt++;
                ks = core_key_size;
                repeat (20) @(posedge clk);
                #1;
                core_cipher = (ks == 8'h20) ? C_CIPH256 : C_CIPH128;
                core_done   = 1'b1;
                @(posedge clk);
                #1;
                core_done   = 1'b0;
            end
        end
    end

    function automatic logic [7:0] fbyte(input logic [127:0] p, input logic [7:0] ks,
                                         input logic [255:0] k, input int idx);
        if (idx < 16)       return p[127 - 8*idx -: 8];
        else if (idx == 16) return ks;
        else                return k[255 - 8*(idx-17) -: 8];
    endfunction

    // One cs assertion, nbits sclk periods (clk/8), mode 0.
    task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        cs = 1'b0;
        #60;
        for (int i = 0; i < nbits; i++) begin
            mosi = tx[7-i];
            #40;
            sclk = 1'b1;
            rx = {rx[6:0], miso};
            #40;
            sclk = 1'b0;
        end
        #40;
        cs = 1'b1;
        #60;
    endtask

    task automatic send_frame(input logic [127:0] p, input logic [7:0] ks, input logic [255:0] k,
                              input int first, input int last);
        logic [7:0] rx;
        for (int i = first; i <= last; i++) begin
            spi_bits(fbyte(p, ks, k, i), 8, rx);
            rx_log[i] = rx;
            rx_or = rx_or | rx;
        end
    endtask

    task automatic wait_enc(input string tag);
        for (int i = 0; i < 3000; i++) begin
            if (enc_sending) break;
            @(negedge clk);
        end
        check(tag, {255'b0, enc_sending}, 256'd1);
    endtask

    task automatic read_cipher(input int nbytes, output logic [127:0] c);
        logic [7:0] rx;
        c = '0;
        for (int i = 0; i < nbytes; i++) begin
            spi_bits(8'h00, 8, rx);
            c = {c[119:0], rx};
        end
    endtask

    task automatic full_frame(input string tag, input logic [127:0] p, input logic [7:0] ks,
                              input logic [255:0] k, input logic [127:0] exp_c);
        logic [127:0] c;
        send_frame(p, ks, k, 0, 48);
        wait_enc({tag, "_enc_rise"});
        read_cipher(16, c);
        check({tag, "_cipher"}, {128'b0, c}, {128'b0, exp_c});
        check({tag, "_enc_fall"}, {255'b0, enc_sending}, 256'd0);
    endtask

    initial begin
        logic [127:0] c;
        logic [7:0]   rx;
        int           s0;

        rx_or = 8'h00;
        repeat (5) @(negedge clk);
        check("rst_miso",     {255'b0, miso}, 256'd0);
        check("rst_done",     {255'b0, done}, 256'd0);
        check("rst_enc",      {255'b0, enc_sending}, 256'd0);
        check("rst_key_err",  {255'b0, key_err}, 256'd0);
        check("rst_start",    {255'b0, core_start}, 256'd0);
        check("rst_plain",    {128'b0, core_plain}, 256'd0);
        check("rst_key",      core_key, 256'd0);
        check("rst_ksize",    {248'b0, core_key_size}, 256'd0);
        reset = 1'b1;
        repeat (5) @(negedge clk);

        // AES-128
        send_frame(C_PLAIN, 8'h10, C_KEY128, 0, 48);
        check("a128_ksize", {248'b0, core_key_size}, 256'h10);
        check("a128_plain", {128'b0, core_plain}, {128'b0, C_PLAIN});
        check("a128_key",   core_key, C_KEY128);
`ifdef SPI_RX_ECHO_EN
        check("echo_first", {248'b0, rx_log[0]}, 256'h00);
        check("echo_byte2", {248'b0, rx_log[2]}, {248'b0, C_PLAIN[119:112]});
`else
        check("rx_miso_zero", {248'b0, rx_or}, 256'h00);
`endif
        wait_enc("a128_enc_rise");
        check("a128_starts", start_cnt, 1);
        read_cipher(16, c);
        check("a128_cipher", {128'b0, c}, {128'b0, C_CIPH128});
        check("a128_enc_fall", {255'b0, enc_sending}, 256'd0);
        check("a128_done", {255'b0, done}, 256'd1);

        // AES-256
        send_frame(C_PLAIN, 8'h20, C_KEY256, 0, 48);
        check("a256_key", core_key, C_KEY256);
        wait_enc("a256_enc_rise");
        read_cipher(16, c);
        check("a256_cipher", {128'b0, c}, {128'b0, C_CIPH256});
        check("a256_starts", start_cnt, 2);

        // Invalid key size: no launch, back to RX_PLAIN after 32 key bytes
        send_frame(C_PLAIN, 8'h11, C_KEY256, 0, 48);
        repeat (200) @(negedge clk);
        check("bad_key_err", {255'b0, key_err}, 256'd1);
        check("bad_no_start", start_cnt, 2);
        check("bad_no_enc", {255'b0, enc_sending}, 256'd0);
        full_frame("after_bad", C_PLAIN, 8'h10, C_KEY128, C_CIPH128);
        check("after_bad_starts", start_cnt, 3);
        check("key_err_sticky", {255'b0, key_err}, 256'd1);

        // cs aborted after 3 bits of byte 5, then byte 5 resent
        send_frame(C_PLAIN2, 8'h10, C_KEY128, 0, 4);
        spi_bits(8'hff, 3, rx);
        send_frame(C_PLAIN2, 8'h10, C_KEY128, 5, 48);
        check("abort_plain", {128'b0, core_plain}, {128'b0, C_PLAIN2});
        wait_enc("abort_enc_rise");
        read_cipher(16, c);
        check("abort_cipher", {128'b0, c}, {128'b0, C_CIPH128});

        // Reset during TX byte 7
        send_frame(C_PLAIN, 8'h10, C_KEY128, 0, 48);
        wait_enc("rtx_enc_rise");
        read_cipher(7, c);
        check("rtx_first7", {200'b0, c[55:0]}, {200'b0, C_CIPH128[127:72]});
        // byte 7 = 0x30: after 3 bits miso carries bit 4 (=1)
        cs = 1'b0;
        #60;
        for (int i = 0; i < 3; i++) begin
            #40; sclk = 1'b1; #40; sclk = 1'b0;
        end
        #40;
        check("rtx_miso_pre", {255'b0, miso}, 256'd1);
        check("rtx_enc_pre", {255'b0, enc_sending}, 256'd1);
        reset = 1'b0;
        #1;
        check("rtx_enc",   {255'b0, enc_sending}, 256'd0);
        check("rtx_done",  {255'b0, done}, 256'd0);
        check("rtx_miso",  {255'b0, miso}, 256'd0);
        check("rtx_start", {255'b0, core_start}, 256'd0);
        check("rtx_kerr",  {255'b0, key_err}, 256'd0);
        check("rtx_plain", {128'b0, core_plain}, 256'd0);
        cs = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        s0 = start_cnt;
        full_frame("post_rst", C_PLAIN, 8'h10, C_KEY128, C_CIPH128);
        check("post_rst_starts", start_cnt, s0 + 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
